// File: rtl/conv_tile_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_tile_sched_if
// Purpose  : Job-request and accelerator-control signal bundle for the
//            convolution tile scheduler. The master modport is the job
//            requester / accelerator side; the slave modport is the scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface conv_tile_sched_if #(
    parameter int ADDR_W = 16
);
    // Job request channel
    logic              job_valid;
    logic              job_ready;
    logic [7:0]        job_tiles;
    logic [1:0]        job_cfg_ci;
    logic [1:0]        job_cfg_co;
    logic [ADDR_W-1:0] job_ifm_base;
    logic [ADDR_W-1:0] job_wgt_base;

    // Accelerator control and read-address channel
    logic [1:0]        cfg_ci;
    logic [1:0]        cfg_co;
    logic              start_conv;
    logic              ifm_read;
    logic              wgt_read;
    logic [ADDR_W-1:0] ifm_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic              ofm_port0_v;
    logic              ofm_port1_v;
    logic              end_conv;

    // Status
    logic              busy;
    logic [7:0]        tile_idx;
    logic [15:0]       ofm_count;
    logic              job_done;
    logic              err_timeout;

    modport master (
        output job_valid, job_tiles, job_cfg_ci, job_cfg_co,
               job_ifm_base, job_wgt_base,
               ifm_read, wgt_read, ofm_port0_v, ofm_port1_v, end_conv,
        input  job_ready, cfg_ci, cfg_co, start_conv, ifm_addr, wgt_addr,
               busy, tile_idx, ofm_count, job_done, err_timeout
    );

    modport slave (
        input  job_valid, job_tiles, job_cfg_ci, job_cfg_co,
               job_ifm_base, job_wgt_base,
               ifm_read, wgt_read, ofm_port0_v, ofm_port1_v, end_conv,
        output job_ready, cfg_ci, cfg_co, start_conv, ifm_addr, wgt_addr,
               busy, tile_idx, ofm_count, job_done, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/conv_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_tile_sched
// Purpose  : Sequences a convolution job as a run of tiles: accepts a job,
//            pulses start_conv per tile, advances the ifm/weight read
//            addresses on accelerator strobes, counts ofm beats and signals
//            job completion.
// Options  : CONV_SCHED_TIMEOUT_EN - when defined, adds a RUN-state watchdog
//            that aborts the job after TIMEOUT_CYCLES and raises err_timeout.
// Revision : 1.0  initial release
// ============================================================================
module conv_tile_sched #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    conv_tile_sched_if.slave  bus
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_start = 3'd1;
    localparam logic [2:0] c_run   = 3'd2;
    localparam logic [2:0] c_next  = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    logic [2:0]        state_q,     state_d;
    logic [7:0]        tiles_q,     tiles_d;
    logic [7:0]        tile_idx_q,  tile_idx_d;
    logic [1:0]        cfg_ci_q,    cfg_ci_d;
    logic [1:0]        cfg_co_q,    cfg_co_d;
    logic [ADDR_W-1:0] ifm_addr_q,  ifm_addr_d;
    logic [ADDR_W-1:0] wgt_addr_q,  wgt_addr_d;
    logic [15:0]       ofm_count_q, ofm_count_d;
    logic              err_q,       err_d;

    logic [16:0]       w_ofm_sum;
    logic [7:0]        w_tile_nxt;
    logic              w_wdog_expire;

    // Extra bit catches the carry so the count can clamp at all-ones
    assign w_ofm_sum  = {1'b0, ofm_count_q} + 17'(bus.ofm_port0_v) + 17'(bus.ofm_port1_v);
    assign w_tile_nxt = tile_idx_q + 8'd1;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

    logic [15:0] wdog_q, wdog_d;

    // Watchdog: counts RUN cycles without end_conv, zero outside RUN
    always_comb begin
        wdog_d = '0;
        if (state_q == c_run && !bus.end_conv) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    assign w_wdog_expire = (state_q == c_run) && !bus.end_conv && (wdog_d == c_timeout);

    // Watchdog register
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign w_wdog_expire = 1'b0;
`endif

    // Next-state and datapath update for the tile sequencer
    always_comb begin
        state_d     = state_q;
        tiles_d     = tiles_q;
        tile_idx_d  = tile_idx_q;
        cfg_ci_d    = cfg_ci_q;
        cfg_co_d    = cfg_co_q;
        ifm_addr_d  = ifm_addr_q;
        wgt_addr_d  = wgt_addr_q;
        ofm_count_d = ofm_count_q;
        err_d       = err_q;

        case (state_q)
            c_idle: begin
                if (bus.job_valid) begin
                    tiles_d     = bus.job_tiles;
                    cfg_ci_d    = bus.job_cfg_ci;
                    cfg_co_d    = bus.job_cfg_co;
                    ifm_addr_d  = bus.job_ifm_base;
                    wgt_addr_d  = bus.job_wgt_base;
                    tile_idx_d  = '0;
                    ofm_count_d = '0;
                    err_d       = 1'b0;
                    state_d     = (bus.job_tiles == 8'd0) ? c_done : c_start;
                end
            end
            c_start: begin
                state_d = c_run;
            end
            c_run: begin
                // Tiles are contiguous in memory: addresses keep running
                if (bus.ifm_read) begin
                    ifm_addr_d = ifm_addr_q + 1'b1;
                end
                if (bus.wgt_read) begin
                    wgt_addr_d = wgt_addr_q + 1'b1;
                end
                if (bus.end_conv) begin
                    state_d = c_next;
                end else if (w_wdog_expire) begin
                    err_d   = 1'b1;
                    state_d = c_done;
                end
            end
            c_next: begin
                tile_idx_d = w_tile_nxt;
                state_d    = (w_tile_nxt == tiles_q) ? c_done : c_start;
            end
            c_done: begin
                state_d = c_idle;
            end
            default: begin
                state_d = c_idle;
            end
        endcase

        // ofm beats are counted in every busy state
        if (state_q != c_idle) begin
            ofm_count_d = w_ofm_sum[16] ? 16'hFFFF : w_ofm_sum[15:0];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_idle;
            tiles_q     <= '0;
            tile_idx_q  <= '0;
            cfg_ci_q    <= '0;
            cfg_co_q    <= '0;
            ifm_addr_q  <= '0;
            wgt_addr_q  <= '0;
            ofm_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tiles_q     <= tiles_d;
            tile_idx_q  <= tile_idx_d;
            cfg_ci_q    <= cfg_ci_d;
            cfg_co_q    <= cfg_co_d;
            ifm_addr_q  <= ifm_addr_d;
            wgt_addr_q  <= wgt_addr_d;
            ofm_count_q <= ofm_count_d;
            err_q       <= err_d;
        end
    end

    assign bus.job_ready   = (state_q == c_idle);
    assign bus.busy        = (state_q != c_idle);
    assign bus.start_conv  = (state_q == c_start);
    assign bus.job_done    = (state_q == c_done);
    assign bus.cfg_ci      = cfg_ci_q;
    assign bus.cfg_co      = cfg_co_q;
    assign bus.ifm_addr    = ifm_addr_q;
    assign bus.wgt_addr    = wgt_addr_q;
    assign bus.tile_idx    = tile_idx_q;
    assign bus.ofm_count   = ofm_count_q;
    assign bus.err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_tile_sched
// Purpose  : Self-checking bench for conv_tile_sched. A job-level model
//            tracks expected addresses, tile index, ofm count and the
//            START/RUN/NEXT/DONE cycle pattern of each job.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_tile_sched;

    localparam int ADDR_W = 16;
    localparam int TO     = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_tile_sched_if #(.ADDR_W(ADDR_W)) bus ();

    conv_tile_sched #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_ifm;
    logic [15:0] exp_wgt;
    int          exp_ofm;
    logic [1:0]  exp_ci;
    logic [1:0]  exp_co;
    logic        exp_err;
    int          exp_tile;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.job_valid    = 1'b0;
        bus.job_tiles    = '0;
        bus.job_cfg_ci   = '0;
        bus.job_cfg_co   = '0;
        bus.job_ifm_base = '0;
        bus.job_wgt_base = '0;
        bus.ifm_read     = 1'b0;
        bus.wgt_read     = 1'b0;
        bus.ofm_port0_v  = 1'b0;
        bus.ofm_port1_v  = 1'b0;
        bus.end_conv     = 1'b0;
    endtask

    // Random traffic on every input; only mode 0 jobs get it
    task automatic noise(input int mode);
        if (mode == 0) begin
            bus.ifm_read     = 1'($urandom_range(0, 1));
            bus.wgt_read     = 1'($urandom_range(0, 1));
            bus.ofm_port0_v  = 1'($urandom_range(0, 1));
            bus.ofm_port1_v  = 1'($urandom_range(0, 1));
            bus.end_conv     = 1'($urandom_range(0, 1));
            bus.job_valid    = 1'($urandom_range(0, 1));
            bus.job_tiles    = 8'($urandom);
            bus.job_cfg_ci   = 2'($urandom);
            bus.job_cfg_co   = 2'($urandom);
            bus.job_ifm_base = 16'($urandom);
            bus.job_wgt_base = 16'($urandom);
        end else begin
            clear_inputs();
        end
    endtask

    // ofm beats presented this cycle count if the scheduler is busy
    task automatic model_ofm(input bit busy_now);
        if (busy_now) begin
            exp_ofm = exp_ofm + int'(bus.ofm_port0_v) + int'(bus.ofm_port1_v);
            if (exp_ofm > 65535) exp_ofm = 65535;
        end
    endtask

    task automatic check_common(input string tag);
        check({tag, "_ifm_addr"}, 32'(bus.ifm_addr), 32'(exp_ifm));
        check({tag, "_wgt_addr"}, 32'(bus.wgt_addr), 32'(exp_wgt));
        check({tag, "_ofm_count"}, 32'(bus.ofm_count), 32'(exp_ofm));
        check({tag, "_cfg"}, {28'd0, bus.cfg_ci, bus.cfg_co}, {28'd0, exp_ci, exp_co});
        check({tag, "_err"}, 32'(bus.err_timeout), 32'(exp_err));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(bus.job_ready), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_start"}, 32'(bus.start_conv), 32'd0);
        check({tag, "_done"}, 32'(bus.job_done), 32'd0);
        check({tag, "_err"}, 32'(bus.err_timeout), 32'd0);
        check({tag, "_cfg"}, {28'd0, bus.cfg_ci, bus.cfg_co}, 32'd0);
        check({tag, "_ifm"}, 32'(bus.ifm_addr), 32'd0);
        check({tag, "_wgt"}, 32'(bus.wgt_addr), 32'd0);
        check({tag, "_tile"}, 32'(bus.tile_idx), 32'd0);
        check({tag, "_ofm"}, 32'(bus.ofm_count), 32'd0);
    endtask

    // Modes: 0 random, 1 fixed 10/4 reads, 2 wrap + dual ofm,
    //        3 long dual-ofm run, 4 long RUN without end_conv
    task automatic run_job(input int tiles, input logic [15:0] ibase,
                           input logic [15:0] wbase, input int mode);
        int         len;
        bit         timed_out;
        logic [1:0] ci;
        logic [1:0] co;
        timed_out = 1'b0;
        ci = 2'($urandom);
        co = 2'($urandom);

        check("idle_ready", 32'(bus.job_ready), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        noise(mode);
        bus.job_valid    = 1'b1;
        bus.job_tiles    = 8'(tiles);
        bus.job_cfg_ci   = ci;
        bus.job_cfg_co   = co;
        bus.job_ifm_base = ibase;
        bus.job_wgt_base = wbase;
        cyc();
        exp_ifm  = ibase;
        exp_wgt  = wbase;
        exp_ofm  = 0;
        exp_ci   = ci;
        exp_co   = co;
        exp_err  = 1'b0;
        exp_tile = 0;

        for (int t = 0; t < tiles && !timed_out; t++) begin
            check("start_pulse", 32'(bus.start_conv), 32'd1);
            check("start_busy", 32'(bus.busy), 32'd1);
            check("start_tile", 32'(bus.tile_idx), 32'(exp_tile));
            check_common("start");
            noise(mode);
            model_ofm(1'b1);
            cyc();

            case (mode)
                0:       len = $urandom_range(1, 6);
                1:       len = 10;
                2:       len = 5;
                3:       len = 33000;
`ifdef CONV_SCHED_TIMEOUT_EN
                default: len = TO;
`else
                default: len = 40;
`endif
            endcase

            for (int i = 0; i < len; i++) begin
                check("run_start_low", 32'(bus.start_conv), 32'd0);
                check("run_busy", 32'(bus.busy), 32'd1);
                check("run_done_low", 32'(bus.job_done), 32'd0);
                check_common("run");
                noise(mode);
                case (mode)
                    1: begin
                        bus.ifm_read = 1'b1;
                        bus.wgt_read = (i < 4);
                    end
                    2: begin
                        bus.ifm_read    = (i < 3);
                        bus.ofm_port0_v = 1'b1;
                        bus.ofm_port1_v = 1'b1;
                    end
                    3: begin
                        bus.ofm_port0_v = 1'b1;
                        bus.ofm_port1_v = 1'b1;
                    end
                    default: ;
                endcase
                bus.end_conv = (i == len - 1);
`ifdef CONV_SCHED_TIMEOUT_EN
                if (mode == 4) bus.end_conv = 1'b0;
`endif
                if (bus.ifm_read) exp_ifm = exp_ifm + 16'd1;
                if (bus.wgt_read) exp_wgt = exp_wgt + 16'd1;
                model_ofm(1'b1);
                cyc();
            end
`ifdef CONV_SCHED_TIMEOUT_EN
            if (mode == 4) begin
                timed_out = 1'b1;
                exp_err   = 1'b1;
            end
`endif
            if (!timed_out) begin
                check("next_start_low", 32'(bus.start_conv), 32'd0);
                check("next_busy", 32'(bus.busy), 32'd1);
                check("next_done_low", 32'(bus.job_done), 32'd0);
                check_common("next");
                noise(mode);
                model_ofm(1'b1);
                cyc();
                exp_tile++;
            end
        end

        check("done_pulse", 32'(bus.job_done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_start_low", 32'(bus.start_conv), 32'd0);
        check("done_tile", 32'(bus.tile_idx), 32'(exp_tile));
        check_common("done");
        noise(mode);
        bus.job_valid = 1'b0;
        model_ofm(1'b1);
        cyc();

        check("post_done_low", 32'(bus.job_done), 32'd0);
        check("post_busy", 32'(bus.busy), 32'd0);
        check("post_ready", 32'(bus.job_ready), 32'd1);
        check("post_tile", 32'(bus.tile_idx), 32'(exp_tile));
        check_common("post");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        check_reset("reset");
        rst = 1'b0;
        cyc();

        // Single tile, fixed read counts
        run_job(1, 16'h0100, 16'h0200, 1);
        check("one_tile_ifm", 32'(bus.ifm_addr), 32'h010A);
        check("one_tile_wgt", 32'(bus.wgt_addr), 32'h0204);
        check("one_tile_idx", 32'(bus.tile_idx), 32'd1);

        // Three tiles with random traffic
        run_job(3, 16'($urandom), 16'($urandom), 0);

        // Zero-tile job goes straight to DONE
        run_job(0, 16'h1234, 16'h5678, 0);

        // Address wrap and dual-port ofm counting
        run_job(1, 16'hFFFE, 16'h0040, 2);
        check("wrap_ifm", 32'(bus.ifm_addr), 32'h0001);
        check("wrap_ofm", 32'(bus.ofm_count), 32'd10);

        // Random jobs
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(0, 5), 16'($urandom), 16'($urandom), 0);
        end

        // Reset in the middle of a RUN
        clear_inputs();
        bus.job_valid    = 1'b1;
        bus.job_tiles    = 8'd2;
        bus.job_cfg_ci   = 2'd3;
        bus.job_cfg_co   = 2'd2;
        bus.job_ifm_base = 16'h0100;
        bus.job_wgt_base = 16'h0300;
        cyc();
        bus.job_valid = 1'b0;
        check("mid_rst_start", 32'(bus.start_conv), 32'd1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus.ifm_read = 1'b1;
            cyc();
        end
        check("mid_rst_pre_ifm", 32'(bus.ifm_addr), 32'h0105);
        rst             = 1'b1;
        bus.ifm_read    = 1'b1;
        bus.ofm_port0_v = 1'b1;
        cyc();
        check_reset("mid_rst");
        rst = 1'b0;
        clear_inputs();
        cyc();
        check_reset("mid_rst_idle");
        run_job(2, 16'($urandom), 16'($urandom), 0);

        // Long RUN without end_conv (watchdog abort when enabled)
        run_job(1, 16'h0800, 16'h0900, 4);
`ifdef CONV_SCHED_TIMEOUT_EN
        check("timeout_sticky", 32'(bus.err_timeout), 32'd1);
        run_job(1, 16'h0010, 16'h0020, 0);
`endif

`ifndef CONV_SCHED_TIMEOUT_EN
        // ofm_count saturation
        run_job(1, 16'h0000, 16'h0000, 3);
        check("sat_ofm", 32'(bus.ofm_count), 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
